vram_arbiter: RTL

//  Parametrised N-client arbiter for the single-port line-wide VRAM.

---
 rtl/vram_arbiter_if.sv | 30 +++
 rtl/vram_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bundle of the client request/grant bus and the VRAM block RAM port.
// The arbiter sits on the slave side; the clients plus the RAM are the master.
interface vram_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int DATA_W      = 640,
    parameter int ADDR_W      = 9
);
    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS-1:0]        req_we;
    logic [NUM_CLIENTS*ADDR_W-1:0] req_addr;
    logic [NUM_CLIENTS*DATA_W-1:0] req_wdata;
    logic [NUM_CLIENTS-1:0]        gnt;
    logic [NUM_CLIENTS-1:0]        rd_valid;
    logic [DATA_W-1:0]             rd_data;
    logic                          vram_en;
    logic                          vram_we;
    logic [ADDR_W-1:0]             vram_addr;
    logic [DATA_W-1:0]             vram_wdata;
    logic [DATA_W-1:0]             vram_rd_data;

    modport slave (
        input  req, req_we, req_addr, req_wdata, vram_rd_data,
        output gnt, rd_valid, rd_data, vram_en, vram_we, vram_addr, vram_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, vram_rd_data,
        input  gnt, rd_valid, rd_data, vram_en, vram_we, vram_addr, vram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin arbiter for the single-port, line-wide VRAM.
// Grants one requesting client per cycle (combinationally, same cycle as req),
// drives the RAM port from the winner, and tags reads in a shift pipe so the
// returned line is flagged only to the client that issued the read.
module vram_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int DATA_W      = 640,
    parameter int ADDR_W      = 9,
    parameter int RD_LATENCY  = 1
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       ptr_d;
    logic                   win_found_s;
    logic [PTR_W-1:0]       win_idx_s;
    logic [NUM_CLIENTS-1:0] gnt_s;
    logic [NUM_CLIENTS-1:0] rd_push_s;
    logic                   vram_en_s;
    logic                   vram_we_s;
    logic [ADDR_W-1:0]      vram_addr_s;
    logic [DATA_W-1:0]      vram_wdata_s;
    logic [NUM_CLIENTS-1:0] rd_valid_s;

    // Read-tag pipe, stored one-hot: bit k set means a read by client k is in flight.
    // The last stage is the registered rd_valid source.
    logic [NUM_CLIENTS-1:0] rd_pipe_q [RD_LATENCY];
    logic [NUM_CLIENTS-1:0] rd_pipe_d [RD_LATENCY];

    // Cyclic search for the first requester starting at the round-robin pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int off = 0; off < NUM_CLIENTS; off++) begin
            if (!win_found_s && !rst && bus.req[(int'(ptr_q) + off) % NUM_CLIENTS]) begin
                win_found_s = 1'b1;
                win_idx_s   = PTR_W'((int'(ptr_q) + off) % NUM_CLIENTS);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant vector and VRAM port drive from the winner; port is zeroed when idle.
    always_comb begin
        gnt_s        = '0;
        vram_en_s    = 1'b0;
        vram_we_s    = 1'b0;
        vram_addr_s  = '0;
        vram_wdata_s = '0;
        if (win_found_s) begin
            gnt_s[win_idx_s] = 1'b1;
            vram_en_s        = 1'b1;
            vram_we_s        = bus.req_we[win_idx_s];
            vram_addr_s      = bus.req_addr[int'(win_idx_s) * ADDR_W +: ADDR_W];
            vram_wdata_s     = bus.req_wdata[int'(win_idx_s) * DATA_W +: DATA_W];
        end else begin
            gnt_s = '0;
        end
    end

    // Pointer advance past the winner and read-tag pipe shift.
    always_comb begin
        ptr_d     = ptr_q;
        rd_push_s = gnt_s & ~bus.req_we;
        if (win_found_s) begin
            ptr_d = PTR_W'((int'(win_idx_s) + 1) % NUM_CLIENTS);
        end else begin
            ptr_d = ptr_q;
        end
        rd_pipe_d[0] = rd_push_s;
        for (int j = 1; j < RD_LATENCY; j++) begin
            rd_pipe_d[j] = rd_pipe_q[j-1];
        end
    end

    // State registers with synchronous reset; reset flushes in-flight read tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int j = 0; j < RD_LATENCY; j++) begin
                rd_pipe_q[j] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int j = 0; j < RD_LATENCY; j++) begin
                rd_pipe_q[j] <= rd_pipe_d[j];
            end
        end
    end

    // rd_valid comes from the pipe tail but is held low for the whole reset pulse.
    always_comb begin
        rd_valid_s = '0;
        if (rst) begin
            rd_valid_s = '0;
        end else begin
            rd_valid_s = rd_pipe_q[RD_LATENCY-1];
        end
    end

    assign bus.gnt        = gnt_s;
    assign bus.vram_en    = vram_en_s;
    assign bus.vram_we    = vram_we_s;
    assign bus.vram_addr  = vram_addr_s;
    assign bus.vram_wdata = vram_wdata_s;
    assign bus.rd_valid   = rd_valid_s;
    assign bus.rd_data    = bus.vram_rd_data;
endmodule
